fetch_unit: RTL and testbench

Instruction fetch front end that feeds the decode stage of the RISC-V core. It owns the program counter and issues in-order word reads to instruction memory over a request/response interface. Returned instructions are buffered in a small queue and presented to decode, along with their PC and PC+4, under a valid/ready handshake. A taken branch or jump, signalled by PCSrc with its PCTarget, redirects fetch and squashes everything already fetched.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/instr_fifo.sv | 73 +++++++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, constants and the fetch queue entry.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Clear the byte offset of an address.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries with flush.
// The caller never pushes when full or pops when empty.
module instr_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next pointers and occupancy; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited in-order
// word reads, queues returned instructions for decode and squashes on redirect.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc_plus4
);

    localparam int unsigned  CW        = $clog2(DEPTH + 1);
    localparam logic [CW:0]  DEPTH_LIM = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]   q_cnt;
    fetch_entry_t    q_head;
    fetch_entry_t    q_push_entry;
    logic            q_push;
    logic            deq;
    logic            credit;
    logic            req_fire;
    logic [CW:0]     occupancy;
    logic [XLEN-1:0] target_pc;

    assign target_pc = word_align(redirect_pc);

    // Handshakes: decode dequeue, request credit and response steering.
    always_comb begin
        dec_valid = (q_cnt != '0) && !redirect;
        deq       = dec_valid && dec_ready;
        // Slots committed after this cycle's dequeue; never exceeds DEPTH.
        occupancy = {1'b0, out_cnt_q} + {1'b0, q_cnt} - {{CW{1'b0}}, deq};
        credit    = occupancy < DEPTH_LIM;
        // Gating with reset keeps the request low while reset is held yet
        // lets the first request go out in the cycle reset is released.
        imem_req_valid = reset && credit && !redirect;
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        // Responses for squashed requests, or arriving with a redirect, are dropped.
        q_push         = imem_rsp_valid && (drop_cnt_q == '0) && !redirect;
        q_push_entry   = '{instr: imem_rsp_data, pc: rsp_pc_q};
    end

    // Next state for the PCs, in-flight count and drop count.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_cnt_d = drop_cnt_q;
        case ({req_fire, imem_rsp_valid})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: out_cnt_d = out_cnt_q;
        endcase
        if (redirect) begin
            fetch_pc_d = target_pc;
            rsp_pc_d   = target_pc;
            // Everything still in flight after this cycle belongs to a dead
            // stream. out_cnt already counts earlier pending drops, so this is
            // the accumulated drop total and stays within DEPTH.
            drop_cnt_d = out_cnt_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rsp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - 1'b1;
                end else begin
                    rsp_pc_d = rsp_pc_q + 32'd4;
                end
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (q_push),
        .push_entry (q_push_entry),
        .pop        (deq),
        .flush      (redirect),
        .head       (q_head),
        .count      (q_cnt)
    );

    // Decode-side outputs; an empty queue shows the next expected PC.
    always_comb begin
        dec_instr    = dec_valid ? q_head.instr : NOP_INSTR;
        dec_pc       = (q_cnt != '0) ? q_head.pc : rsp_pc_q;
        dec_pc_plus4 = dec_pc + 32'd4;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with variable latency, a stream-level
// reference model of what decode must see, and directed literal checks.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus4;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_pc_plus4   (dec_pc_plus4)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } log_t;

    mreq_t       mem_q[$];     // accepted requests awaiting their response
    logic [31:0] m_q[$];       // PCs the decode queue must hold
    logic [31:0] next_fetch;
    logic [31:0] next_consume;
    int          epoch;
    int          cyc;
    int          dropped;
    log_t        req_log[$];
    log_t        con_log[$];

    int          lat_min, lat_max, rdy_pct, dec_pct, redir_pct;
    logic        force_redirect;
    logic [31:0] force_target;
    logic        last_req_valid, last_dec_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // One clock cycle: drive at negedge, compare just before posedge, advance model.
    task automatic cycle();
        logic        rdir, rsp, deq, exp_valid, exp_req, acc, keep;
        logic [31:0] tgt;
        int          outn, d;
        mreq_t       h;
        rdir = force_redirect || ($urandom_range(99) < 32'(redir_pct));
        tgt  = force_redirect ? force_target : $urandom;
        redirect       = rdir;
        redirect_pc    = tgt;
        dec_ready      = ($urandom_range(99) < 32'(dec_pct));
        imem_req_ready = ($urandom_range(99) < 32'(rdy_pct));
        rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom;
        #4;
        exp_valid = (m_q.size() != 0) && !rdir;
        deq       = exp_valid && dec_ready;
        outn      = mem_q.size();
        exp_req   = ((outn + m_q.size() - (deq ? 1 : 0)) < DEPTH) && !rdir;
        chk("dec_valid", 32'(dec_valid), 32'(exp_valid));
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req) chk("req_addr", imem_req_addr, next_fetch);
        if (exp_valid) begin
            chk("dec_pc", dec_pc, m_q[0]);
            chk("dec_instr", dec_instr, mem_word(m_q[0]));
            chk("dec_pc_plus4", dec_pc_plus4, m_q[0] + 32'd4);
        end else begin
            chk("dec_instr_nop", dec_instr, NOP_INSTR);
        end
        chk("inflight_bound", 32'((outn + m_q.size()) <= DEPTH), 32'd1);
        last_req_valid = imem_req_valid;
        last_dec_valid = dec_valid;
        acc = imem_req_valid && imem_req_ready;
        if (deq) begin
            chk("stream_pc", dec_pc, next_consume);
            con_log.push_back('{cyc: cyc, a: dec_pc, b: dec_pc_plus4});
            next_consume = next_consume + 32'd4;
            void'(m_q.pop_front());
        end
        if (rsp) begin
            h    = mem_q.pop_front();
            keep = !rdir && (h.epoch == epoch);
            if (keep) begin
                chk("no_full_enqueue", 32'(m_q.size() < DEPTH), 32'd1);
                m_q.push_back(h.addr);
            end else begin
                dropped++;
            end
        end
        if (acc) begin
            d = cyc + int'($urandom_range(32'(lat_max), 32'(lat_min)));
            mem_q.push_back('{addr: imem_req_addr, due: d, epoch: epoch});
            req_log.push_back('{cyc: cyc, a: imem_req_addr, b: 32'd0});
            next_fetch = next_fetch + 32'd4;
        end
        if (rdir) begin
            m_q.delete();
            epoch++;
            next_fetch   = {tgt[31:2], 2'b00};
            next_consume = {tgt[31:2], 2'b00};
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        mem_q.delete(); m_q.delete(); req_log.delete(); con_log.delete();
        next_fetch = RESET_PC; next_consume = RESET_PC; epoch = 0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_instr", dec_instr, NOP_INSTR);
        chk("rst_dec_pc", dec_pc, RESET_PC);
        chk("rst_dec_pc_plus4", dec_pc_plus4, RESET_PC + 32'd4);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        int d0;
        force_redirect = 1'b0; force_target = '0; dropped = 0; cyc = 0;
        lat_min = 1; lat_max = 1; rdy_pct = 100; dec_pct = 100; redir_pct = 0;
        do_reset();

        // Streaming from reset with 1-cycle memory.
        run(8);
        if (req_log.size() >= 3 && con_log.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("a_req_addr", req_log[i].a, 32'(4 * i));
                chk("a_req_cyc", 32'(req_log[i].cyc), 32'(i + 1));
                chk("a_dec_pc", con_log[i].a, 32'(4 * i));
                chk("a_dec_cyc", 32'(con_log[i].cyc), 32'(i + 3));
                chk("a_dec_plus4", con_log[i].b, 32'(4 * i + 4));
            end
        end else begin
            chk("a_log_size", 32'(con_log.size()), 32'd3);
        end
        chk("a_throughput", 32'(con_log.size()), 32'd6);

        // Quiesce, then reset and hold decode off for 10 cycles.
        dec_pct = 0;
        n = 0;
        while (!(mem_q.size() == 0 && m_q.size() == DEPTH) && n < 20) begin
            cycle(); n++;
        end
        chk("quiesce_timeout", 32'(n < 20), 32'd1);
        do_reset();
        run(10);
        chk("b_req_count", 32'(req_log.size()), 32'(DEPTH));
        chk("b_req_stalled", 32'(last_req_valid), 32'd0);
        dec_pct = 100;
        run(6);
        if (con_log.size() >= 3) begin
            chk("b_first_pc", con_log[0].a, 32'h0);
            chk("b_second_pc", con_log[1].a, 32'h4);
            chk("b_third_pc", con_log[2].a, 32'h8);
        end else begin
            chk("b_log_size", 32'(con_log.size()), 32'd3);
        end

        // Redirect to 0x100 with two responses in flight.
        lat_min = 3; lat_max = 3;
        n = 0;
        while (!(mem_q.size() == 2 && mem_q[0].due > cyc) && n < 30) begin
            cycle(); n++;
        end
        chk("c_wait_timeout", 32'(n < 30), 32'd1);
        req_log.delete(); con_log.delete();
        d0 = dropped;
        force_redirect = 1'b1; force_target = 32'h100;
        cycle();
        force_redirect = 1'b0;
        chk("c_redirect_dec_valid", 32'(last_dec_valid), 32'd0);
        run(12);
        chk("c_dropped", 32'(dropped - d0), 32'd2);
        if (con_log.size() > 0) chk("c_first_pc", con_log[0].a, 32'h100);
        else chk("c_log_size", 32'(con_log.size()), 32'd1);

        // Redirect coinciding with a response, then a second to 0x200.
        lat_min = 1; lat_max = 1;
        run(6);
        n = 0;
        while (!(mem_q.size() > 0 && mem_q[0].due <= cyc) && n < 10) begin
            cycle(); n++;
        end
        chk("d_wait_timeout", 32'(n < 10), 32'd1);
        req_log.delete(); con_log.delete();
        force_redirect = 1'b1; force_target = 32'h180;
        cycle();
        force_target = 32'h200;
        cycle();
        force_redirect = 1'b0;
        run(10);
        chk("d_progress", 32'(con_log.size() >= 5), 32'd1);
        foreach (con_log[i]) chk("d_stream_pc", con_log[i].a, 32'h200 + 32'(4 * i));

        // Redirect to an unaligned target at the top of the address space.
        req_log.delete(); con_log.delete();
        force_redirect = 1'b1; force_target = 32'hFFFF_FFFE;
        cycle();
        force_redirect = 1'b0;
        run(8);
        if (req_log.size() >= 2 && con_log.size() >= 2) begin
            chk("e_req0", req_log[0].a, 32'hFFFF_FFFC);
            chk("e_req1", req_log[1].a, 32'h0000_0000);
            chk("e_dec_pc", con_log[0].a, 32'hFFFF_FFFC);
            chk("e_dec_plus4", con_log[0].b, 32'h0000_0000);
            chk("e_dec_pc_next", con_log[1].a, 32'h0000_0000);
        end else begin
            chk("e_log_size", 32'(con_log.size()), 32'd2);
        end

        // Random latency, back-pressure, request stalls and redirects.
        lat_min = 1; lat_max = 5; rdy_pct = 70; dec_pct = 60; redir_pct = 3;
        con_log.delete();
        run(3000);
        chk("f_progress", 32'(con_log.size() > 300), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
